// File: rtl/rename_pkg.sv
// Shared rename-stage constants and tag/pointer types.
package rename_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ARCH_REGS = 32;
  localparam int PR_NUM    = ROB_DEPTH + 33;
  localparam int TAG_W     = $clog2(PR_NUM);
  localparam int PTR_W     = $clog2(ROB_DEPTH) + 1;
  localparam int ZERO_TAG  = ROB_DEPTH + 32;

  typedef logic [TAG_W-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/free_list.sv
// Physical-register free list for a 2-wide rename stage.
// Circular buffer of free tags with wrap-bit head/tail pointers, in-order
// 2-wide allocation, 2-wide T_old reclaim, and head-snapshot branch recovery.
// ROB_DEPTH must be a power of two so pointers wrap naturally.
// Optional: define FREE_LIST_BYPASS_EN to let same-cycle retire tags be
// allocated directly without passing through the buffer.
module free_list #(
  parameter int ROB_DEPTH = rename_pkg::ROB_DEPTH,
  parameter int TAG_W     = $clog2(ROB_DEPTH + 33),
  parameter int PTR_W     = $clog2(ROB_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_req_0,
  input  logic             dispatch_req_1,
  input  logic             is_0_br,
  input  logic             br_dispatch,
  input  logic             retire_valid_0,
  input  logic             retire_valid_1,
  input  logic [TAG_W-1:0] retire_tag_0,
  input  logic [TAG_W-1:0] retire_tag_1,
  input  logic             recovery_br,
  input  logic [PTR_W-1:0] recovery_head,
  output logic [TAG_W-1:0] alloc_tag_0,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic             alloc_valid_0,
  output logic             alloc_valid_1,
  output logic             stall,
  output logic [PTR_W-1:0] head_snapshot,
  output logic [PTR_W-1:0] free_count
);

  localparam int IDX_W = PTR_W - 1;

  logic [TAG_W-1:0] r_fl [ROB_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_count;

  logic [1:0]       w_n_req;
  logic [1:0]       w_n_ret;
  logic [1:0]       w_n_grant;
  logic [1:0]       w_n_from_fl;
  logic [1:0]       w_n_bypass;
  logic [1:0]       w_n_write;
  logic [1:0]       w_n_snap;
  logic [PTR_W:0]   w_avail;
  logic [TAG_W-1:0] w_ret_tag [2];
  logic [TAG_W-1:0] w_pos_tag [2];
  logic [TAG_W-1:0] w_wr_tag  [2];
  logic             w_grant_0;
  logic             w_grant_1;
  logic             w_overflow;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;

  // Allocation, reclaim compaction and next-pointer arithmetic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    w_n_grant = 2'd0;
    w_grant_0 = 1'b0;
    w_grant_1 = 1'b0;

    w_n_req = {1'b0, dispatch_req_0} + {1'b0, dispatch_req_1};
    w_n_ret = {1'b0, retire_valid_0} + {1'b0, retire_valid_1};

    // Retire tags compacted into slot order.
    w_ret_tag[0] = retire_valid_0 ? retire_tag_0 : retire_tag_1;
    w_ret_tag[1] = retire_tag_1;

`ifdef FREE_LIST_BYPASS_EN
    w_avail      = {1'b0, r_count} + (PTR_W+1)'(w_n_ret);
    w_pos_tag[0] = (r_count != '0) ? r_fl[r_head[IDX_W-1:0]] : w_ret_tag[0];
    if (r_count >= PTR_W'(2))
      w_pos_tag[1] = r_fl[IDX_W'(r_head + PTR_W'(1))];
    else if (r_count == PTR_W'(1))
      w_pos_tag[1] = w_ret_tag[0];
    else
      w_pos_tag[1] = w_ret_tag[1];
`else
    w_avail      = {1'b0, r_count};
    w_pos_tag[0] = r_fl[r_head[IDX_W-1:0]];
    w_pos_tag[1] = r_fl[IDX_W'(r_head + PTR_W'(1))];
`endif

    stall = (PTR_W+1)'(w_n_req) > w_avail;

    if (!recovery_br)
      w_n_grant = ((PTR_W+1)'(w_n_req) <= w_avail) ? w_n_req : w_avail[1:0];

    // Grants are handed out in request order; a lone req_1 takes position 0.
    w_grant_0 = dispatch_req_0 && (w_n_grant != 2'd0);
    w_grant_1 = dispatch_req_1 && (dispatch_req_0 ? (w_n_grant == 2'd2)
                                                  : (w_n_grant != 2'd0));

    alloc_tag_0 = w_pos_tag[0];
    alloc_tag_1 = (dispatch_req_1 && !dispatch_req_0) ? w_pos_tag[0] : w_pos_tag[1];

    // Grants beyond the registered count were served by bypassed retire tags.
    w_n_from_fl = (PTR_W'(w_n_grant) <= r_count) ? w_n_grant : r_count[1:0];
    w_n_bypass  = w_n_grant - w_n_from_fl;
    w_n_write   = w_n_ret - w_n_bypass;
    w_wr_tag[0] = w_ret_tag[w_n_bypass[0]];
    w_wr_tag[1] = w_ret_tag[1];

    w_overflow  = ({1'b0, r_count} + (PTR_W+1)'(w_n_write)) > (PTR_W+1)'(ROB_DEPTH);
    w_tail_next = w_overflow ? r_tail : r_tail + PTR_W'(w_n_write);
    w_head_next = recovery_br ? recovery_head : r_head + PTR_W'(w_n_from_fl);

    // Snapshot covers only the grants older than or equal to the branch.
    w_n_snap      = (br_dispatch && is_0_br) ? {1'b0, w_grant_0} : w_n_grant;
    head_snapshot = r_head + ((PTR_W'(w_n_snap) <= r_count) ? PTR_W'(w_n_snap) : r_count);
  end

  assign alloc_valid_0 = w_grant_0;
  assign alloc_valid_1 = w_grant_1;
  assign free_count    = r_count;

  // Buffer writes and pointer/count registers; reset refills with tags 32..63.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the buffer is reset because its initial contents are the free tags.
      for (int i = 0; i < ROB_DEPTH; i++)
        r_fl[i] <= TAG_W'(rename_pkg::ARCH_REGS + i);
      r_head  <= '0;
      r_tail  <= {1'b1, {IDX_W{1'b0}}};
      r_count <= PTR_W'(ROB_DEPTH);
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!w_overflow) begin
        if (w_n_write != 2'd0)
          r_fl[r_tail[IDX_W-1:0]] <= w_wr_tag[0];
        if (w_n_write == 2'd2)
          r_fl[IDX_W'(r_tail + PTR_W'(1))] <= w_wr_tag[1];
      end
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_tail_next - w_head_next;
    end
  end

  // Reclaiming more tags than the buffer holds indicates a ROB bug upstream.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !w_overflow);

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: an absolute-position free-tag model
// produces expectations that are queued at drive time and popped at sample time.
module tb_free_list;
  import rename_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            dispatch_req_0, dispatch_req_1, is_0_br, br_dispatch;
  logic            retire_valid_0, retire_valid_1;
  phys_tag_t       retire_tag_0, retire_tag_1;
  logic            recovery_br;
  fl_ptr_t         recovery_head;
  phys_tag_t       alloc_tag_0, alloc_tag_1;
  logic            alloc_valid_0, alloc_valid_1, stall;
  fl_ptr_t         head_snapshot, free_count;

  typedef struct {
    bit v0, v1, stall;
    int t0, t1, snap, fc;
  } exp_t;

  exp_t exp_q[$];
  int   m_tags[$];      // every tag ever in the list, by absolute position
  int   head_abs;
  int   last_snap_abs;
  int   n_checks = 0;
  int   n_errors = 0;

  free_list dut (
    .clock(clock), .reset(reset),
    .dispatch_req_0(dispatch_req_0), .dispatch_req_1(dispatch_req_1),
    .is_0_br(is_0_br), .br_dispatch(br_dispatch),
    .retire_valid_0(retire_valid_0), .retire_valid_1(retire_valid_1),
    .retire_tag_0(retire_tag_0), .retire_tag_1(retire_tag_1),
    .recovery_br(recovery_br), .recovery_head(recovery_head),
    .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
    .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
    .stall(stall), .head_snapshot(head_snapshot), .free_count(free_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pos_tag(input int i, input int cnt, input int rl[$]);
    if (i < cnt) return m_tags[head_abs + i];
    if (i - cnt < rl.size()) return rl[i - cnt];
    return -1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input bit r0, input bit r1, input bit br, input bit is0,
                      input bit rv0, input bit rv1, input int rt0, input int rt1,
                      input bit rec, input int rec_abs);
    exp_t e, s;
    int   cnt, avail, nreq, k, kk, ffl, nbyp;
    int   rl[$];
    @(negedge clock);
    dispatch_req_0 = r0;  dispatch_req_1 = r1;
    br_dispatch    = br;  is_0_br        = is0;
    retire_valid_0 = rv0; retire_valid_1 = rv1;
    retire_tag_0   = TAG_W'(rt0); retire_tag_1 = TAG_W'(rt1);
    recovery_br    = rec; recovery_head  = PTR_W'(rec_abs % 64);

    cnt = m_tags.size() - head_abs;
    if (rv0) rl.push_back(rt0);
    if (rv1) rl.push_back(rt1);
    avail = cnt;
`ifdef FREE_LIST_BYPASS_EN
    avail += rl.size();
`endif
    nreq    = int'(r0) + int'(r1);
    k       = rec ? 0 : imin(nreq, avail);
    e.stall = nreq > avail;
    e.fc    = cnt;
    if (r0) begin
      e.v0 = (k >= 1); e.t0 = pos_tag(0, cnt, rl);
      e.v1 = r1 && (k >= 2); e.t1 = pos_tag(1, cnt, rl);
    end else begin
      e.v0 = 1'b0; e.t0 = -1;
      e.v1 = r1 && (k >= 1); e.t1 = pos_tag(0, cnt, rl);
    end
    kk = (br && is0) ? int'(e.v0) : int'(e.v0) + int'(e.v1);
    e.snap = (head_abs + imin(kk, cnt)) % 64;
    if (br) last_snap_abs = head_abs + imin(kk, cnt);
    exp_q.push_back(e);

    #1;
    s = exp_q.pop_front();
    check("free_count", free_count, s.fc);
    check("stall", stall, s.stall);
    check("alloc_valid_0", alloc_valid_0, s.v0);
    check("alloc_valid_1", alloc_valid_1, s.v1);
    if (s.v0) check("alloc_tag_0", alloc_tag_0, s.t0);
    if (s.v1) check("alloc_tag_1", alloc_tag_1, s.t1);
    check("head_snapshot", head_snapshot, s.snap);

    ffl  = imin(k, cnt);
    nbyp = k - ffl;
    for (int i = nbyp; i < rl.size(); i++) m_tags.push_back(rl[i]);
    head_abs = rec ? rec_abs : head_abs + ffl;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dual();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int br_abs, cnt, nret;
    bit rv0, rv1;
    reset = 1'b1;
    dispatch_req_0 = 0; dispatch_req_1 = 0; is_0_br = 0; br_dispatch = 0;
    retire_valid_0 = 0; retire_valid_1 = 0; retire_tag_0 = '0; retire_tag_1 = '0;
    recovery_br = 0; recovery_head = '0;
    for (int i = 0; i < 32; i++) m_tags.push_back(32 + i);
    head_abs = 0;
    last_snap_abs = 0;

    // Reset must win over requests and retires driven in the same cycle.
    @(negedge clock);
    dispatch_req_0 = 1; dispatch_req_1 = 1; retire_valid_0 = 1; retire_tag_0 = 7'd3;
    @(negedge clock);
    reset = 0;
    dispatch_req_0 = 0; dispatch_req_1 = 0; retire_valid_0 = 0;
    #1;
    check("reset_tag_0", alloc_tag_0, 32);
    check("reset_tag_1", alloc_tag_1, 33);
    check("reset_valid_0", alloc_valid_0, 0);
    check("reset_valid_1", alloc_valid_1, 0);
    check("reset_stall", stall, 0);
    check("reset_free_count", free_count, 32);

    // Dual dispatch down to two free tags, then lone req_1, then partial grant.
    for (int i = 0; i < 15; i++) dual();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    dual();
    dual();

    // Retire then reuse; a lone retire_valid_1 is compacted to slot order.
    step(0, 0, 0, 0, 1, 1, 5, 40, 0, 0);
    dual();
    step(0, 0, 0, 0, 0, 1, 0, 9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Empty list with a same-cycle retire: bypassed or stalled per build.
    step(1, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    idle();

    // Refill, then branch dispatch, further allocation and recovery.
    for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 1, 1, 10 + 2*j, 11 + 2*j, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    br_abs = last_snap_abs;
    dual(); dual(); dual();
    step(1, 1, 0, 0, 1, 0, 50, 0, 1, br_abs);
    dual();
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Random legal traffic across pointer wrap.
    for (int n = 0; n < 80; n++) begin
      cnt = m_tags.size() - head_abs;
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      nret = int'(rv0) + int'(rv1);
      if (cnt + nret > 32) begin rv0 = 0; rv1 = 0; end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rv0, rv1, $urandom_range(0, 64), $urandom_range(0, 64), 0, 0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the 2-wide R10K-style rename stage.
- Sits directly upstream of the map table: supplies new tags (`free_list_in_0/1`) and grant strobes (`fetch_PR_0/1`).
- Reclaims T_old tags from ROB retirement.
- Supports branch checkpoint and recovery by head-pointer snapshot, so it stays consistent with map-table recovery.

Parameters:
- ROB_DEPTH, 32, number of free-list slots; equals ROB entries (PR count = ROB_DEPTH+33).
- TAG_W, $clog2(ROB_DEPTH+33), physical tag width.
- PTR_W, $clog2(ROB_DEPTH)+1, pointer width; MSB is the wrap bit.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dispatch_req_0  in  1  slot-0 instruction needs a destination tag
- dispatch_req_1  in  1  slot-1 instruction needs a destination tag
- is_0_br  in  1  a branch is dispatched in slot 0 (otherwise in slot 1 when br_dispatch)
- br_dispatch  in  1  a branch dispatches this cycle; snapshot is valid
- retire_valid_0  in  1  ROB retires head instruction with a T_old to free
- retire_valid_1  in  1  second retiring instruction frees a T_old
- retire_tag_0  in  TAG_W  T_old freed by retire slot 0
- retire_tag_1  in  TAG_W  T_old freed by retire slot 1
- recovery_br  in  1  mispredict; restore head from recovery_head
- recovery_head  in  PTR_W  head snapshot taken at branch dispatch
- alloc_tag_0  out  TAG_W  tag for slot 0 (to map table free_list_in_0)
- alloc_tag_1  out  TAG_W  tag for slot 1
- alloc_valid_0  out  1  slot-0 grant (to fetch_PR_0)
- alloc_valid_1  out  1  slot-1 grant (to fetch_PR_1)
- stall  out  1  requests exceed free tags; dispatch must hold
- head_snapshot  out  PTR_W  head after the branch's allocation, for the branch stack
- free_count  out  PTR_W  registered number of free tags

Behaviour:
- **Storage and state**
  - Circular buffer `fl[ROB_DEPTH]` of TAG_W tags; registered `head`, `tail` (PTR_W, wrap bit) and `count`.
  - `count` = tail - head (mod 2*ROB_DEPTH).
- **Reset**
  - `fl[i]` = 32+i for i in 0..ROB_DEPTH-1; head=0; tail = wrap bit 1, index 0 (full); count=ROB_DEPTH.
  - After reset: alloc_tag_0=32, alloc_tag_1=33, alloc_valid=0, stall=0, free_count=ROB_DEPTH.
  - Reset wins over all other inputs in the same cycle.
- **Allocation** (combinational, zero latency)
  - Request list is the ordered subset of {req_0, req_1}. The first request takes `fl[head]`, the second takes `fl[head+1]`.
  - If only req_1 is asserted, slot 1 receives `fl[head]`.
  - Grants = min(#requests, count).
  - Partial grant is in order: with req_0 and req_1 both set and count==1, only slot 0 is granted.
  - stall = (#requests > count).
  - All grants are forced to 0 while recovery_br=1.
  - head advances by #grants at the clock edge.
- **Retire**
  - Valid retire tags are written at `tail`, then `tail+1`, in slot order (compacted if only retire_valid_1).
  - tail advances by #retires.
  - Retired tags are not allocatable until the next cycle unless FREE_LIST_BYPASS_EN is defined.
- **Overflow**
  - count + retires > ROB_DEPTH is illegal. The simulation assertion fires; the write is dropped.
- **Snapshot**
  - head_snapshot = head + (is_0_br ? grant_0 : grant_0+grant_1), combinational.
  - Meaningful only when br_dispatch=1; otherwise it equals head + grants.
- **Recovery**
  - On recovery_br: head <= recovery_head. Same-cycle retires still update tail; allocations are discarded.
  - Next-cycle count = tail_next - recovery_head.
- **Wrap-around**
  - Indices use the low PTR_W-1 bits.
  - head == tail with equal wrap bits means empty; differing wrap bits means full.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- **Defined:** same-cycle retire tags become allocatable.
  - Effective availability = count + #retires.
  - A request at position i (i = 0 or 1) takes `fl[head+i]` if i < count, else retire tag (i-count) in slot order.
  - Bypassed tags are not written into `fl`; tail advances only by the retire tags not bypassed (net tail/head movement is consistent).
  - Stall is evaluated against the effective availability.
- **Undefined:** availability = registered count only.

Decomposition:
- Shared package `rename_pkg`:
  - constants PR_NUM = ROB_DEPTH+33, TAG_W, ZERO_TAG = ROB_DEPTH+32, ARCH_REGS = 32;
  - typedef `phys_tag_t` (logic [TAG_W-1:0]);
  - typedef `fl_ptr_t` (logic [PTR_W-1:0]).
- No sub-module: pointer arithmetic and the 2-wide read/write muxing fit in a single module.

Test Plan:
1. **Reset, then dual dispatch:** reset, then req_0=req_1=1 → alloc 32,33 with both valid; next cycle 34,35; free_count 32→30→28.
2. **Drain to empty:** 16 cycles of dual requests → stall=0 throughout; 17th cycle dual request → stall=1, alloc_valid=00, free_count=0.
3. **One entry left:** count=1, req_0=req_1=1 → alloc_valid_0=1 only, stall=1. With only req_1=1 → slot 1 receives `fl[head]`.
4. **Retire then reuse:** from empty, retire tags 5 and 40 → free_count=2 next cycle; dual request → alloc 5,40.
5. **Branch recovery:** at head=4, br_dispatch with is_0_br=0 and dual grant → head_snapshot=6. Then 3 more dual allocations (head=12). recovery_br with recovery_head=6 and one retire the same cycle → head=6, alloc_valid=00 that cycle, count = tail_next-6.
6. **Bypass (FREE_LIST_BYPASS_EN):** count=0, retire tag 7, req_0=1 → alloc_tag_0=7, alloc_valid_0=1 in the same cycle, tail unchanged. Without the macro → stall=1.
